// File: rtl/sap_pkg.sv
// Shared SAP constants and the memory-clear FSM state encoding.
package sap_pkg;

  localparam int SAP_ADDR_WIDTH = 4;
  localparam int SAP_DATA_WIDTH = 8;

  typedef enum logic {
    MEM_IDLE  = 1'b0,
    MEM_CLEAR = 1'b1
  } mem_state_e;

endpackage

// File: rtl/sap_rising_edge.sv
// One-shot pulse on the rising edge of a level input. The input history is
// registered; the pulse is high for the single cycle where the input is 1
// and the registered copy is still 0.
module sap_rising_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic din_q;
  logic din_d;

  // History register tracks the input every cycle, whatever the mode.
  always_comb din_d = din;

  // Async reset clears history so a button held through reset fires once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) din_q <= 1'b0;
    else     din_q <= din_d;
  end

  assign pulse = din & ~din_q;

endmodule

// File: rtl/sap_memory_unit.sv
// SAP RAM subsystem: MAR, program/run address mux, RAM array, single-shot
// manual write and a hardware clear sweep that zeroes every word.
module sap_memory_unit
  import sap_pkg::*;
#(
  parameter int ADDR_WIDTH = SAP_ADDR_WIDTH,
  parameter int DATA_WIDTH = SAP_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  prog_mode,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data,
  input  logic                  prog_write,
  input  logic [DATA_WIDTH-1:0] bus_in,
  input  logic                  mar_load,
  input  logic                  ram_load,
  input  logic                  ram_out,
  input  logic                  clear_req,
  output logic [DATA_WIDTH-1:0] bus_out,
  output logic                  bus_oe,
  output logic [ADDR_WIDTH-1:0] mar_q,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // MAR is loaded from the bus, so the bus must be at least as wide.
  if (DATA_WIDTH < ADDR_WIDTH) begin : g_width_check
    $error("sap_memory_unit: DATA_WIDTH must be >= ADDR_WIDTH");
  end

  mem_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] mar_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  prog_pulse;
  logic                  run_en;
  logic [ADDR_WIDTH-1:0] eff_addr;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;

  sap_rising_edge u_prog_edge (
    .clk   (clk),
    .rst   (reset),
    .din   (prog_write),
    .pulse (prog_pulse)
  );

  assign busy     = (state_q == MEM_CLEAR);
  assign run_en   = ~prog_mode & ~busy;
  assign eff_addr = prog_mode ? prog_addr : mar_q;

  // Output enable is also forced low while reset is held.
  assign bus_oe  = ram_out & ~prog_mode & ~busy & ~reset;
  assign bus_out = bus_oe ? mem[eff_addr] : '0;

  // Clear sweep: one word per cycle, leaves after writing the last address.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      MEM_IDLE: begin
        if (clear_req) begin
          state_d = MEM_CLEAR;
          ptr_d   = '0;
        end
      end
      MEM_CLEAR: begin
        ptr_d = ptr_q + ADDR_WIDTH'(1);
        if (ptr_q == '1) state_d = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  // MAR loads only in run mode outside a sweep; upper bus bits are dropped.
  always_comb begin
    mar_d = mar_q;
    if (run_en && mar_load) mar_d = bus_in[ADDR_WIDTH-1:0];
  end

  // Single write port arbitration: sweep, then manual write, then run write.
  // Run write uses the pre-update MAR when mar_load is also asserted.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (busy) begin
      we    = 1'b1;
      waddr = ptr_q;
    end else if (prog_mode && prog_pulse) begin
      we    = 1'b1;
      waddr = prog_addr;
      wdata = prog_data;
    end else if (!prog_mode && ram_load) begin
      we    = 1'b1;
      waddr = mar_q;
      wdata = bus_in;
    end
  end

  // Control state with async reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MEM_IDLE;
      ptr_q   <= '0;
      mar_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mar_q   <= mar_d;
    end
  end

  // RAM array holds its contents across reset; writes are blocked while held.
  always_ff @(posedge clk) begin
    if (we && !reset) mem[waddr] <= wdata;
  end

endmodule

// File: tb/tb_sap_memory_unit.sv
// Self-checking bench for sap_memory_unit: reference memory model plus a
// scoreboard queue of expected read words.
module tb_sap_memory_unit;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          prog_mode;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;
  logic          prog_write;
  logic [DW-1:0] bus_in;
  logic          mar_load;
  logic          ram_load;
  logic          ram_out;
  logic          clear_req;
  logic [DW-1:0] bus_out;
  logic          bus_oe;
  logic [AW-1:0] mar_q;
  logic          busy;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] sbq [$];

  sap_memory_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .prog_mode  (prog_mode),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_write (prog_write),
    .bus_in     (bus_in),
    .mar_load   (mar_load),
    .ram_load   (ram_load),
    .ram_out    (ram_out),
    .clear_req  (clear_req),
    .bus_out    (bus_out),
    .bus_oe     (bus_oe),
    .mar_q      (mar_q),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    prog_mode = 1'b0;
    bus_in = DW'(a); mar_load = 1'b1; ram_load = 1'b0;
    tick();
    bus_in = d; mar_load = 1'b0; ram_load = 1'b1;
    tick();
    ram_load = 1'b0;
    model[a] = d;
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] a);
    logic [DW-1:0] e;
    prog_mode = 1'b0;
    bus_in = DW'(a); mar_load = 1'b1; ram_out = 1'b0;
    tick();
    mar_load = 1'b0; ram_out = 1'b1;
    sbq.push_back(model[a]);
    @(negedge clk);
    e = sbq.pop_front();
    chk(tag, bus_out, e);
    ram_out = 1'b0;
  endtask

  task automatic fill(input logic [DW-1:0] d);
    for (int i = 0; i < DEPTH; i++) wr(AW'(i), d);
  endtask

  initial begin
    int n;
    reset = 1'b1; prog_mode = 1'b0; prog_addr = '0; prog_data = '0;
    prog_write = 1'b0; bus_in = '0; mar_load = 1'b0; ram_load = 1'b0;
    ram_out = 1'b1; clear_req = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mar", mar_q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_oe", bus_oe, 0);
    chk("rst_out", bus_out, 0);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_oe", bus_oe, 1);
    ram_out = 1'b0;
    tick();

    // Known contents everywhere before targeted tests
    fill(8'h11);

    // Run write/read
    wr(4'h3, 8'hA5);
    ram_out = 1'b1;
    @(negedge clk);
    chk("run_mar", mar_q, 3);
    chk("run_rd", bus_out, 8'hA5);
    ram_out = 1'b0;
    bus_in = 8'hF7; mar_load = 1'b1;
    tick();
    mar_load = 1'b0;
    chk("mar_trunc", mar_q, 4'h7);

    // Program mode single-shot write
    prog_mode = 1'b1; prog_addr = 4'h2; prog_data = 8'h3C; prog_write = 1'b1;
    ram_out = 1'b1;
    tick();
    prog_data = 8'hFF;
    model[2] = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("prog_oe", bus_oe, 0);
      tick();
    end
    prog_write = 1'b0; ram_out = 1'b0;
    tick();
    rd("prog_mem2", 4'h2);

    // Run write ignored in program mode, prog_write ignored in run mode
    prog_mode = 1'b1; ram_load = 1'b1; bus_in = 8'hEE;
    tick();
    ram_load = 1'b0; prog_mode = 1'b0; prog_addr = 4'h2; prog_data = 8'h99;
    prog_write = 1'b1;
    tick();
    prog_write = 1'b0;
    tick();
    rd("gate_mem2", 4'h2);

    // Simultaneous MAR load and RAM write
    wr(4'h5, 8'h77);
    bus_in = 8'h01; mar_load = 1'b1;
    tick();
    bus_in = 8'h05; mar_load = 1'b1; ram_load = 1'b1;
    tick();
    mar_load = 1'b0; ram_load = 1'b0;
    model[1] = 8'h05;
    chk("sim_mar", mar_q, 5);
    rd("sim_mem1", 4'h1);
    rd("sim_mem5", 4'h5);

    // Full clear sweep with loads and clear_req asserted while busy
    fill(8'h55);
    chk("pre_clr_mar", mar_q, 4'hF);
    clear_req = 1'b1;
    tick();
    bus_in = 8'h9A; mar_load = 1'b1; ram_load = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    clear_req = 1'b0; mar_load = 1'b0; ram_load = 1'b0;
    chk("clr_cycles", n, DEPTH);
    chk("clr_mar_hold", mar_q, 4'hF);
    tick();
    chk("clr_no_restart", busy, 0);
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    for (int i = 0; i < DEPTH; i++) rd($sformatf("clr_mem%0d", i), AW'(i));

    // Reset in the middle of a sweep
    fill(8'h55);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (6) tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) model[i] = 8'h00;
    for (int i = 0; i < DEPTH; i++) rd($sformatf("mid_mem%0d", i), AW'(i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sap_memory_unit.md
Name: sap_memory_unit

Overview:
Parametrised RAM subsystem for the SAP data path. It combines the memory address register, the program/run address mux and the RAM array into one clocked block. It adds a debounced-style single-shot program write and a hardware memory-clear sweep. It sits between the shared data bus and the control unit, replacing the discrete register, mux and RAM chips of the first-generation machine.

Parameters:
ADDR_WIDTH, 4, address bits; memory depth DEPTH = 2**ADDR_WIDTH (derived, not overridable).
DATA_WIDTH, 8, word width; DATA_WIDTH >= ADDR_WIDTH is required, and elaboration must fail otherwise.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
prog_mode  input  1  1 = program mode (manual switches), 0 = run mode (bus/control).
prog_addr  input  ADDR_WIDTH  manual address switches.
prog_data  input  DATA_WIDTH  manual data switches.
prog_write  input  1  manual write button, level; acted on at its rising edge only.
bus_in  input  DATA_WIDTH  data bus value.
mar_load  input  1  load MAR from bus_in[ADDR_WIDTH-1:0].
ram_load  input  1  write bus_in to mem[MAR].
ram_out  input  1  drive the read word onto bus_out.
clear_req  input  1  start the memory-clear sweep.
bus_out  output  DATA_WIDTH  read word when enabled, else 0.
bus_oe  output  1  bus_out is valid and driving.
mar_q  output  ADDR_WIDTH  current MAR value.
busy  output  1  clear sweep in progress.

Behaviour:
- Reset (async, immediate):
  - mar_q=0, busy=0, FSM=IDLE, sweep pointer=0, prog_write history register=0.
  - bus_out=0, bus_oe=0.
  - Memory contents are not reset; they hold whatever was written before.
- Effective address: eff_addr = prog_mode ? prog_addr : mar_q.
- Read path (asynchronous, combinational):
  - rd = mem[eff_addr].
  - bus_oe = ram_out & ~prog_mode & ~busy.
  - bus_out = bus_oe ? rd : 0.
- MAR: on a clock edge with ~prog_mode & ~busy & mar_load, mar_q <= bus_in[ADDR_WIDTH-1:0]; otherwise it holds.
- Run write: on a clock edge with ~prog_mode & ~busy & ram_load, mem[mar_q] <= bus_in.
  - mar_load and ram_load in the same cycle: the write uses the old mar_q, and MAR updates at the same edge.
- Program write:
  - prog_write is registered every cycle into prog_write_d.
  - A write fires at the edge where prog_write=1 & prog_write_d=0 & prog_mode & ~busy: mem[prog_addr] <= prog_data.
  - Holding the button produces exactly one write.
- Mode gating: in program mode, mar_load, ram_load and ram_out are ignored. In run mode, prog_write is ignored, but prog_write_d still tracks it.
- Clear FSM:
  - IDLE: clear_req=1 -> CLEAR, ptr=0, busy=1 from the next cycle.
  - CLEAR: each edge writes mem[ptr] <= 0 and increments ptr. When ptr=DEPTH-1 is written -> IDLE, busy=0.
  - The sweep takes exactly DEPTH cycles. ptr wraps naturally and must not overrun.
  - clear_req while in CLEAR is ignored, and no restart occurs.
- Write priority: clear sweep > program write > run write. Only one write per cycle.
- Reset mid-sweep: the FSM returns to IDLE and busy=0 immediately. Already-cleared words stay 0; the remaining words keep their contents.
- Widths: bus_in upper bits above ADDR_WIDTH are discarded on MAR load. No arithmetic is performed on data.

Decomposition:
- Shared package sap_pkg holds:
  - default SAP_ADDR_WIDTH=4 and SAP_DATA_WIDTH=8 constants;
  - the memory-clear FSM state enum (MEM_IDLE, MEM_CLEAR).
- One sub-module: sap_rising_edge (registered one-shot pulse generator with async active-high reset), instantiated for prog_write.

Test Plan:
- Reset with prog_mode=0, ram_out=1 -> mar_q=0, busy=0, bus_oe=0 during reset; after release, bus_oe=1.
- Run write/read: bus_in=8'h03 with mar_load, then bus_in=8'hA5 with ram_load, then ram_out=1 -> mar_q=3 and bus_out=8'hA5. A load with bus_in=8'hF7 -> mar_q=4'h7.
- Program mode: prog_addr=2, prog_data=8'h3C, prog_write held high 5 cycles, while prog_data changes to 8'hFF after the first edge -> mem[2]=8'h3C (single write); bus_oe=0 throughout.
- Simultaneous: mar_q=1, mar_load=1 with bus_in=8'h05 and ram_load=1 -> mem[1]=8'h05, mar_q=5, mem[5] unchanged.
- Clear: fill all 16 words with 8'h55, pulse clear_req -> busy high for exactly 16 cycles; afterwards, reads of every address give 8'h00. ram_load and mar_load asserted during busy have no effect.
- Reset mid-sweep: assert reset after 6 sweep cycles -> busy=0 at once; addresses 0-5 read 8'h00, addresses 6-15 read 8'h55.
